// File: rtl/mem_pkg.sv
// Shared definitions for the banked-RAM requester: FSM encoding, bank map,
// rw polarity and CPU-side request/response records.
package mem_pkg;

  localparam int BANK_LSB  = 24;
  localparam int NUM_BANKS = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_ACCESS = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/access_timer.sv
// Loadable 4-bit down-counter; done flags the last cycle of a loaded interval.
module access_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 4'd1);

endmodule

// File: rtl/mem_requester.sv
// Turns one CPU load/store at a time into a SETUP / ACCESS / HOLD sequence
// on the banked RAM, then presents the response until the CPU takes it.
module mem_requester #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int NUM_BANKS   = mem_pkg::NUM_BANKS,
  parameter int BANK_LSB    = mem_pkg::BANK_LSB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out,
  output logic [15:0]       txn_count
);

  import mem_pkg::state_t;
  import mem_pkg::ST_IDLE;
  import mem_pkg::ST_SETUP;
  import mem_pkg::ST_ACCESS;
  import mem_pkg::ST_HOLD;
  import mem_pkg::ST_RESP;
  import mem_pkg::RW_READ;
  import mem_pkg::RW_WRITE;

  localparam int BANK_W = ADDR_W - BANK_LSB;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rw_q, rw_d;
  logic [15:0]       txn_count_q, txn_count_d;
  logic [BANK_W-1:0] bank_field;
  logic              bank_ok;
  logic              timer_done;

  assign bank_field = req_addr[ADDR_W-1:BANK_LSB];
  assign bank_ok    = (bank_field < BANK_W'(NUM_BANKS));

  access_timer u_access_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_SETUP),
    .load_val_i(4'(WAIT_CYCLES)),
    .en_i      (state_q == ST_ACCESS),
    .done_o    (timer_done)
  );

  // Out-of-range banks skip the RAM and leave address/data untouched.
  // rsp_valid comes up one cycle after entering RESP on that path.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    txn_count_d = txn_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          rdata_d = '0;
          err_d   = !bank_ok;
          if (bank_ok) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (timer_done) begin
          state_d = ST_HOLD;
          if (we_q == RW_READ) begin
            rdata_d = mem_out;
          end
        end
      end
      ST_HOLD: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rw_d = (state_d == ST_ACCESS) && (we_q == RW_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      txn_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rw_q        <= rw_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign mem_address = addr_q;
  assign mem_dataIn  = wdata_q;
  assign mem_rw      = rw_q;
  assign txn_count   = txn_count_q;

endmodule
